// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: shared state type, guard-bit constant and width helpers
// for the CORDIC vectoring scheduler.
package cordic_sched_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, ITER, DSCALE, DSWAIT, RESP} sched_state_t;

   localparam int GUARD_BITS = 2;

   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Sign bits fill the guard positions; the operand sits just below them.
   function automatic logic [63:0] upscale(input logic signed [31:0] x, input int dw, input int cw);
      return 64'(x) << (cw - dw - GUARD_BITS);
   endfunction

endpackage

// File: rtl/cordic_vec_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; the requester just after
// last has the highest priority.
module rr_arbiter import cordic_sched_pkg::*; #(
   parameter int N_REQ = 2,
   localparam int TAG_W = tag_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [TAG_W-1:0] last,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [TAG_W-1:0] grant_idx
);

   // Scan farthest-first so the nearest requester overwrites any earlier hit.
   always_comb begin
      grant = '0;
      grant_idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         if (en && req[(int'(last) + i) % N_REQ]) begin
            grant = '0;
            grant[(int'(last) + i) % N_REQ] = 1'b1;
            grant_idx = TAG_W'((int'(last) + i) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/cordic_vec_sched.sv
// cordic_vec_sched: shares one iterative vectoring CORDIC core and its
// downscale stage between N_REQ requesters, round-robin.
module cordic_vec_sched import cordic_sched_pkg::*; #(
   parameter int CORDIC_WIDTH = 22,
   parameter int DATA_WIDTH = 16,
   parameter int N_ITER = 16,
   parameter int N_REQ = 2,
   localparam int TAG_W = tag_width(N_REQ),
   localparam int ITER_W = tag_width(N_ITER)
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_x,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_y,
   output logic                        core_load,
   output logic [CORDIC_WIDTH-1:0]     core_x_in,
   output logic [CORDIC_WIDTH-1:0]     core_y_in,
   output logic                        core_iter_en,
   output logic [ITER_W-1:0]           core_iter,
   output logic                        ds_enable,
   input  logic [DATA_WIDTH-1:0]       ds_x_out,
   input  logic                        ds_op_vld,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [TAG_W-1:0]            out_tag,
   output logic                        busy
);

   sched_state_t                 state;
   logic [ITER_W-1:0]            iter_cnt;
   logic [TAG_W-1:0]             last;
   logic [TAG_W-1:0]             grant_idx;
   logic [N_REQ-1:0]             grant;
   logic signed [DATA_WIDTH-1:0] sel_x;
   logic signed [DATA_WIDTH-1:0] sel_y;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req(req_valid),
      .last(last),
      .en(state == IDLE),
      .grant(grant),
      .grant_idx(grant_idx)
   );

   assign req_ready = grant;
   assign core_iter = iter_cnt;
   assign sel_x = req_x[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_y = req_y[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

   // Operands are upscaled at grant time and held on core_x_in/core_y_in.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
         iter_cnt <= '0;
         last <= TAG_W'(N_REQ - 1);
         core_load <= 1'b0;
         core_iter_en <= 1'b0;
         ds_enable <= 1'b0;
         out_valid <= 1'b0;
         busy <= 1'b0;
         core_x_in <= '0;
         core_y_in <= '0;
         out_data <= '0;
         out_tag <= '0;
      end else begin
         core_load <= 1'b0;
         ds_enable <= 1'b0;
         case (state)
            IDLE: if (|grant) begin
               state <= LOAD;
               last <= grant_idx;
               out_tag <= grant_idx;
               core_x_in <= CORDIC_WIDTH'(upscale(32'(sel_x), DATA_WIDTH, CORDIC_WIDTH));
               core_y_in <= CORDIC_WIDTH'(upscale(32'(sel_y), DATA_WIDTH, CORDIC_WIDTH));
               core_load <= 1'b1;
               busy <= 1'b1;
            end
            LOAD: begin
               state <= ITER;
               iter_cnt <= '0;
               core_iter_en <= 1'b1;
            end
            ITER: if (iter_cnt == ITER_W'(N_ITER - 1)) begin
               state <= DSCALE;
               core_iter_en <= 1'b0;
               ds_enable <= 1'b1;
            end else begin
               iter_cnt <= iter_cnt + 1'b1;
            end
            DSCALE: state <= DSWAIT;
            DSWAIT: if (ds_op_vld) begin
               state <= RESP;
               out_data <= ds_x_out;
               out_valid <= 1'b1;
            end
            RESP: if (out_ready) begin
               state <= IDLE;
               out_valid <= 1'b0;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vec_sched.sv
// tb_cordic_vec_sched: randomized requesters against behavioural core and
// downscale models; a scoreboard checks magnitude, tag, order and timing.
module tb_cordic_vec_sched;

   localparam int CW = 22, DW = 16, NI = 16, NR = 2, TW = 1, IW = 4;
   localparam int UPS = 1 << (CW - DW - 2);
   localparam real K = 1.646760258;

   logic clk = 1'b0, nreset = 1'b0;
   logic [NR-1:0] req_valid = '0, req_ready;
   logic [NR*DW-1:0] req_x = '0, req_y = '0;
   logic core_load, core_iter_en, ds_enable, out_valid, busy;
   logic [CW-1:0] core_x_in, core_y_in;
   logic [IW-1:0] core_iter;
   logic [DW-1:0] ds_x_out = '0, out_data;
   logic ds_op_vld = 1'b0, out_ready = 1'b0;
   logic [TW-1:0] out_tag;

   typedef struct {int who; int x; int y;} stim_t;
   typedef struct {int tag; int x; int y; int acc;} job_t;
   stim_t pend[$];
   job_t q[$];
   int glog[$];
   int total = 0, bad = 0, cyc = 0, rdy_mode = 0;
   int mlast = NR - 1, iter_n = 0, ds_n = 0;
   bit in_flight = 0, seq_ok = 1, prev_ov = 0;
   logic [DW-1:0] held_d = '0;
   logic [TW-1:0] held_t = '0;
   logic [NR-1:0] acc_f = '0;
   longint cx = 0, cy = 0;

   cordic_vec_sched dut (
      .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .core_load(core_load), .core_x_in(core_x_in),
      .core_y_in(core_y_in), .core_iter_en(core_iter_en), .core_iter(core_iter),
      .ds_enable(ds_enable), .ds_x_out(ds_x_out), .ds_op_vld(ds_op_vld),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++)
         if (v[(last + k) % NR]) return NR'(1) << ((last + k) % NR);
      return '0;
   endfunction

   function automatic int exp_mag(input int x, input int y);
      return int'(K * $sqrt(real'(longint'(x) * x + longint'(y) * y)) / 4.0);
   endfunction

   // Behavioural vectoring core: rotates (x,y) toward the positive x axis.
   always @(posedge clk) begin
      if (core_load) begin
         cx <= ($signed(core_x_in) < 0) ? -longint'($signed(core_x_in)) : longint'($signed(core_x_in));
         cy <= ($signed(core_x_in) < 0) ? -longint'($signed(core_y_in)) : longint'($signed(core_y_in));
      end else if (core_iter_en) begin
         if (cy >= 0) begin
            cx <= cx + (cy >>> core_iter);
            cy <= cy - (cx >>> core_iter);
         end else begin
            cx <= cx - (cy >>> core_iter);
            cy <= cy + (cx >>> core_iter);
         end
      end
   end

   // Registered downscale stage, plus stray valid pulses in unrelated cycles.
   always @(posedge clk) begin
      ds_op_vld <= ds_enable || ($urandom_range(7) == 0);
      ds_x_out <= ds_enable ? DW'(cx >>> (CW - DW)) : DW'($urandom);
   end

   // Requesters hold their head entry until it is accepted.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NR; i++)
         if (acc_f[i])
            for (int k = 0; k < pend.size(); k++)
               if (pend[k].who == i) begin
                  pend.delete(k);
                  break;
               end
      acc_f = '0;
      req_valid = '0;
      for (int i = 0; i < NR; i++)
         for (int k = 0; k < pend.size(); k++)
            if (pend[k].who == i) begin
               req_valid[i] = 1'b1;
               req_x[i*DW +: DW] = DW'(pend[k].x);
               req_y[i*DW +: DW] = DW'(pend[k].y);
               break;
            end
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom() & 1) : 1'b0;
   end

   always @(negedge clk) begin
      logic [NR-1:0] eg;
      int g, e, d, tol;
      job_t j;
      if (!nreset) begin
         q.delete();
         in_flight = 0;
         mlast = NR - 1;
         prev_ov = 0;
         acc_f = '0;
      end else begin
         if (core_load) begin
            iter_n = 0;
            ds_n = 0;
            seq_ok = 1;
            if (q.size() > 0)
               chk(core_x_in == CW'(q[0].x * UPS) && core_y_in == CW'(q[0].y * UPS),
                   "upscale", core_x_in, CW'(q[0].x * UPS));
         end
         if (core_iter_en) begin
            if (int'(core_iter) != iter_n) seq_ok = 0;
            iter_n++;
         end
         if (ds_enable) ds_n++;
         if (out_valid && !prev_ov) begin
            held_d = out_data;
            held_t = out_tag;
            chk(q.size() != 0, "valid_has_job", q.size(), 1);
            if (q.size() > 0) begin
               chk(cyc - q[0].acc == NI + 4, "latency", cyc - q[0].acc, NI + 4);
               chk(iter_n == NI && seq_ok, "iter_seq", iter_n, NI);
               chk(ds_n == 1, "ds_pulses", ds_n, 1);
            end
         end else if (out_valid) begin
            chk(out_data == held_d && out_tag == held_t, "hold", out_data, held_d);
         end
         prev_ov = out_valid;
         eg = in_flight ? '0 : rr_pick(req_valid, mlast);
         chk(req_ready == eg, "grant", req_ready, eg);
         if (|(req_ready & req_valid)) begin
            g = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
            q.push_back('{g, int'($signed(req_x[g*DW +: DW])), int'($signed(req_y[g*DW +: DW])), cyc});
            glog.push_back(g);
            acc_f[g] = 1'b1;
            in_flight = 1;
            mlast = g;
         end
         if (out_valid && out_ready) begin
            if (q.size() > 0) begin
               j = q.pop_front();
               chk(int'(out_tag) == j.tag, "tag", out_tag, j.tag);
               e = exp_mag(j.x, j.y);
               tol = (j.x == 0 && j.y == 0) ? 0 : 4;
               d = int'($signed(out_data)) - e;
               chk(d <= tol && d >= -tol, "magnitude", $signed(out_data), e);
            end
            in_flight = 0;
         end
      end
   end

   task automatic push(input int w, input int x, input int y);
      pend.push_back('{w, x, y});
   endtask

   function automatic int rnd();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   task automatic wait_idle(input int lim);
      int n = 0;
      while ((pend.size() != 0 || q.size() != 0 || in_flight) && n < lim) begin
         @(posedge clk);
         n++;
      end
      chk(n < lim, "drain", n, lim);
   endtask

   task automatic chk_zero(input string nm);
      chk(req_ready == '0, {nm, "_ready"}, req_ready, 0);
      chk({core_load, core_iter_en, ds_enable, out_valid, busy} == '0, {nm, "_ctl"},
          {core_load, core_iter_en, ds_enable, out_valid, busy}, 0);
      chk(core_x_in == '0 && core_y_in == '0, {nm, "_core_in"}, core_x_in, 0);
      chk(core_iter == '0, {nm, "_iter"}, core_iter, 0);
      chk(out_data == '0 && out_tag == '0, {nm, "_out"}, out_data, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #2 chk_zero("reset");
      @(posedge clk);
      #3 nreset = 1'b1;

      push(0, 16384, 0);
      wait_idle(300);

      push(0, -32768, -32768);
      push(1, 0, 0);
      wait_idle(300);

      glog.delete();
      for (int i = 0; i < 3; i++) begin
         push(0, rnd(), rnd());
         push(1, rnd(), rnd());
      end
      wait_idle(600);
      chk(glog.size() == 6, "contention_count", glog.size(), 6);
      for (int i = 1; i < glog.size(); i++)
         chk(glog[i] != glog[i-1], "alternate", glog[i], 1 - glog[i-1]);

      rdy_mode = 2;
      push(1, rnd(), rnd());
      push(0, rnd(), rnd());
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk(n < 100, "bp_wait", n, 100);
      repeat (10) @(posedge clk);
      rdy_mode = 0;
      wait_idle(300);

      rdy_mode = 1;
      for (int i = 0; i < 24; i++) push(int'($urandom_range(NR - 1)), rnd(), rnd());
      wait_idle(3000);

      rdy_mode = 0;
      push(0, 12000, -7000);
      n = 0;
      do begin
         @(posedge clk);
         #2 n++;
      end while (!(core_iter_en && core_iter == 4'd7) && n < 100);
      chk(n < 100, "iter7_wait", n, 100);
      #1 nreset = 1'b0;
      #1 chk_zero("abort");
      glog.delete();
      push(1, rnd(), rnd());
      push(0, rnd(), rnd());
      repeat (2) @(posedge clk);
      #3 nreset = 1'b1;
      wait_idle(300);
      chk(glog.size() > 0 && glog[0] == 0, "post_reset_first", (glog.size() > 0) ? glog[0] : -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
